// File: rtl/fazyrv_rf_pkg.sv
// Shared types and constants for the FazyRV register-file RAM.
package fazyrv_rf_pkg;

  localparam int unsigned NO_X_REGS   = 32;
  localparam int unsigned NO_CSRS_CSR = 8;

  typedef enum logic [1:0] {
    StRst,
    StClr,
    StRun
  } rf_ram_state_e;

  function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/fazyrv_rf_ram_clr.sv
// Post-reset clear sequencer: sweeps every address once, then releases busy.
module fazyrv_rf_ram_clr
  import fazyrv_rf_pkg::*;
#(
  parameter int unsigned Depth   = 40,
  parameter int unsigned Adrw    = $clog2(Depth),
  parameter bit          InitClr = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            clr_we_o,
  output logic [Adrw-1:0] clr_addr_o,
  output logic            busy_o
);

  localparam logic [Adrw-1:0] LastAddr = Adrw'(Depth - 1);

  rf_ram_state_e   state_q, state_d;
  logic [Adrw-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    unique case (state_q)
      StRst: state_d = InitClr ? StClr : StRun;
      StClr: begin
        clr_we_o = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: ;
      default: state_d = StRst;
    endcase
  end

  assign clr_addr_o = cnt_q;
  assign busy_o     = (state_q != StRun);

endmodule

// File: rtl/fazyrv_rf_ram.sv
// Register-file RAM with 1 or 2 registered read ports, one write port and a post-reset clear.
module fazyrv_rf_ram
  import fazyrv_rf_pkg::*;
#(
  parameter int unsigned     Regw    = 32,
  parameter int unsigned     Depth   = NO_X_REGS + NO_CSRS_CSR,
  parameter int unsigned     Adrw    = $clog2(Depth),
  parameter int unsigned     Nrd     = 2,
  parameter bit              Bypass  = 1'b1,
  parameter bit              InitClr = 1'b1,
  parameter logic [Regw-1:0] InitVal = '0
) (
  input  logic            clk_i,
  input  logic            rst_in,
  input  logic            we_i,
  input  logic [Adrw-1:0] waddr_i,
  input  logic [Regw-1:0] wdata_i,
  input  logic            re_i,
  input  logic [Adrw-1:0] raddr_a_i,
  output logic [Regw-1:0] rdata_a_o,
  input  logic [Adrw-1:0] raddr_b_i,
  output logic [Regw-1:0] rdata_b_o,
  output logic            busy_o,
  output logic            core_rst_no
);

  logic            busy, clr_we;
  logic [Adrw-1:0] clr_addr;

  fazyrv_rf_ram_clr #(
    .Depth  (Depth),
    .Adrw   (Adrw),
    .InitClr(InitClr)
  ) u_clr (
    .clk_i     (clk_i),
    .rst_ni    (rst_in),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr),
    .busy_o    (busy)
  );

  logic [Regw-1:0] mem_q [Depth];
  logic            user_we, mem_we;
  logic [Adrw-1:0] mem_waddr;
  logic [Regw-1:0] mem_wdata;

  assign user_we = we_i && addr_ok(32'(waddr_i), Depth);

  // The sequencer owns the write port until the sweep is done.
  always_comb begin
    mem_we    = rst_in && user_we;
    mem_waddr = waddr_i;
    mem_wdata = wdata_i;
    if (busy) begin
      mem_we    = clr_we;
      mem_waddr = clr_addr;
      mem_wdata = InitVal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  logic [Adrw-1:0] raddr [2];
  logic [Regw-1:0] rdata [2];

  assign raddr[0] = raddr_a_i;
  assign raddr[1] = raddr_b_i;

  for (genvar g = 0; g < 2; g++) begin : g_rd
    if (g < Nrd) begin : g_port
      logic [Regw-1:0] rdata_d, rdata_q;

      always_comb begin
        rdata_d = '0;
        if (Bypass && user_we && (waddr_i == raddr[g])) begin
          rdata_d = wdata_i;
        end else if (addr_ok(32'(raddr[g]), Depth)) begin
          rdata_d = mem_q[raddr[g]];
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_in) begin
          rdata_q <= '0;
        end else if (re_i && !busy) begin
          rdata_q <= rdata_d;
        end
      end

      assign rdata[g] = rdata_q;
    end else begin : g_tie
      logic unused_raddr;
      assign unused_raddr = ^raddr[g];
      assign rdata[g]     = '0;
    end
  end

  assign rdata_a_o   = rdata[0];
  assign rdata_b_o   = rdata[1];
  assign busy_o      = busy;
  assign core_rst_no = ~busy;

endmodule

// File: tb/tb_fazyrv_rf_ram.sv
// Directed bench: three configurations driven with the same stimulus, checked per instance.
module tb_fazyrv_rf_ram;

  localparam int unsigned Depth = 40;
  localparam int unsigned Adrw  = 6;

  logic            clk, rst_n, we, re;
  logic [Adrw-1:0] waddr, raddr_a, raddr_b;
  logic [31:0]     wdata;

  logic [31:0] a0, b0, a1, b1, a2, b2;
  logic        busy0, busy1, busy2, crst0, crst1, crst2;

  int n_run  = 0;
  int n_fail = 0;

  // Default config: two ports, write-first, clear sweep.
  fazyrv_rf_ram #(.Depth(Depth)) dut (
    .clk_i(clk), .rst_in(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .re_i(re),
    .raddr_a_i(raddr_a), .rdata_a_o(a0), .raddr_b_i(raddr_b), .rdata_b_o(b0),
    .busy_o(busy0), .core_rst_no(crst0)
  );

  // Read-first variant.
  fazyrv_rf_ram #(.Depth(Depth), .Bypass(1'b0)) dut_rf (
    .clk_i(clk), .rst_in(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .re_i(re),
    .raddr_a_i(raddr_a), .rdata_a_o(a1), .raddr_b_i(raddr_b), .rdata_b_o(b1),
    .busy_o(busy1), .core_rst_no(crst1)
  );

  // Single read port, no clear sweep.
  fazyrv_rf_ram #(.Depth(Depth), .Nrd(1), .InitClr(1'b0)) dut_n1 (
    .clk_i(clk), .rst_in(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .re_i(re),
    .raddr_a_i(raddr_a), .rdata_a_o(a2), .raddr_b_i(raddr_b), .rdata_b_o(b2),
    .busy_o(busy2), .core_rst_no(crst2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Releases reset (called just after an edge that sampled rst_n=0) and counts busy cycles.
  task automatic release_and_count(output int c0, output int c1, output int c2);
    c0 = 0;
    c1 = 0;
    c2 = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!(busy0 || busy1 || busy2)) break;
      if (busy0) c0++;
      if (busy1) c1++;
      if (busy2) c2++;
      step();
    end
  endtask

  task automatic write(input logic [Adrw-1:0] addr, input logic [31:0] data);
    we    = 1'b1;
    waddr = addr;
    wdata = data;
    step();
    we = 1'b0;
  endtask

  task automatic read(input logic [Adrw-1:0] ra, input logic [Adrw-1:0] rb);
    re      = 1'b1;
    raddr_a = ra;
    raddr_b = rb;
    step();
    re = 1'b0;
  endtask

  int c0, c1, c2;

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr_a = '0; raddr_b = '0; wdata = '0;
    repeat (3) step();

    check_eq("rst_busy", 32'(busy0), 32'd1);
    check_eq("rst_core_rst_n", 32'(crst0), 32'd0);
    check_eq("rst_rdata_a", a0, 32'h0);
    check_eq("rst_rdata_b", b0, 32'h0);

    // Test 1: busy length and cleared contents.
    release_and_count(c0, c1, c2);
    check_eq("busy_len_clr", 32'(c0), 32'd41);
    check_eq("busy_len_clr_rf", 32'(c1), 32'd41);
    check_eq("busy_len_noclr", 32'(c2), 32'd1);
    check_eq("core_rst_n_run", 32'(crst0), 32'd1);
    for (int i = 0; i < 40; i++) begin
      read(Adrw'(i), Adrw'(39 - i));
      check_eq($sformatf("clr_rd_a[%0d]", i), a0, 32'h0);
      check_eq($sformatf("clr_rd_b[%0d]", 39 - i), b0, 32'h0);
    end

    // Test 2: plain write then read on both ports.
    write(6'd5, 32'hDEADBEEF);
    read(6'd5, 6'd5);
    check_eq("wr_rd_a", a0, 32'hDEADBEEF);
    check_eq("wr_rd_b", b0, 32'hDEADBEEF);
    check_eq("wr_rd_a_rf", a1, 32'hDEADBEEF);
    check_eq("wr_rd_a_n1", a2, 32'hDEADBEEF);
    check_eq("n1_port_b_zero", b2, 32'h0);

    // Test 3: same-edge write/read collision.
    write(6'd7, 32'h000000AA);
    we = 1'b1; waddr = 6'd7; wdata = 32'h1234;
    read(6'd7, 6'd7);
    we = 1'b0;
    check_eq("coll_bypass_a", a0, 32'h1234);
    check_eq("coll_bypass_b", b0, 32'h1234);
    check_eq("coll_readfirst_a", a1, 32'h000000AA);
    check_eq("coll_readfirst_b", b1, 32'h000000AA);
    read(6'd7, 6'd0);
    check_eq("coll_after_a", a1, 32'h1234);
    check_eq("coll_after_b", b1, 32'h0);

    // Test 5: read hold and out-of-range accesses.
    read(6'd5, 6'd7);
    raddr_a = 6'd7;
    step();
    check_eq("hold_a", a0, 32'hDEADBEEF);
    raddr_a = 6'd0;
    step();
    check_eq("hold_a2", a0, 32'hDEADBEEF);
    check_eq("hold_b", b0, 32'h1234);
    write(6'd45, 32'h55555555);
    read(6'd45, 6'd13);
    check_eq("oor_rd_a", a0, 32'h0);
    check_eq("oor_no_alias_b", b0, 32'h0);
    read(6'd5, 6'd45);
    check_eq("oor_keep_5", a0, 32'hDEADBEEF);
    check_eq("oor_rd_b", b0, 32'h0);

    // Test 4: reset mid-sweep restarts the clear.
    write(6'd30, 32'hCAFE0030);
    read(6'd30, 6'd30);
    check_eq("pre_rst_30", a0, 32'hCAFE0030);
    rst_n = 1'b0;
    step();
    check_eq("rst2_rdata_a", a0, 32'h0);
    rst_n = 1'b1;
    re = 1'b1; raddr_a = 6'd30;
    we = 1'b1; waddr = 6'd30; wdata = 32'h77;
    repeat (20) step();
    check_eq("sweep_busy", 32'(busy0), 32'd1);
    check_eq("sweep_core_rst_n", 32'(crst0), 32'd0);
    check_eq("sweep_rd_ignored", a0, 32'h0);
    re = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    step();
    release_and_count(c0, c1, c2);
    check_eq("busy_len_restart", 32'(c0), 32'd41);
    check_eq("busy_len_restart_n1", 32'(c2), 32'd1);
    read(6'd30, 6'd5);
    check_eq("clr_30", a0, 32'h0);
    check_eq("clr_5", b0, 32'h0);
    check_eq("clr_30_rf", a1, 32'h0);
    check_eq("noclr_30_n1", a2, 32'h77);
    check_eq("n1_port_b_zero2", b2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
